_xnor_rx: RTL
=============

# _xnor_rx

Serial parity-frame receiver: the checking end of the XNOR-chain parity path. It deserialises a framed bit stream (start, DATA_WIDTH data bits LSB first, parity, stop). It recomputes parity with the same XNOR chain seeded from DigitSupply[1] and presents the word with parity and framing status. It sits between a bit-level link and word-level logic that consumes `_xnor`-protected data.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 1..32.
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- DigitSupply  input  2  supply rails: [1] = logic-1 (parity seed), [0] = logic-0; both static.
- serialData  input  1  received line bit; sampled only when serialValid=1.
- serialValid  input  1  bit strobe; one bit per cycle in which it is high.
- outputData  output  DATA_WIDTH  last successfully framed word; held until the next good frame.
- outputValid  output  1  one-cycle pulse: outputData and parityError were updated this cycle.
- parityError  output  1  1 = received parity ≠ computed parity; qualified by outputValid, held with outputData.
- frameError  output  1  one-cycle pulse: stop bit sampled as 0; frame discarded.
- busy  output  1  1 while in DATA, PARITY or STOP.

## Operation
- Parity rule: running value p starts at DigitSupply[1]; for each data bit d, p ← ~(p ^ d). Expected parity = final p = seed ^ (^data) ^ (DATA_WIDTH odd). This matches the `_xnor` generator bit-for-bit.
- States: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with serialValid=1; otherwise state, counter and shift register hold.
- IDLE: serialData=0 → DATA, with bitCount←0 and p←DigitSupply[1]. serialData=1 (line idle) → stay in IDLE.
- DATA: shift serialData into shift[bitCount] (LSB first), update p, and increment bitCount. At bitCount = DATA_WIDTH-1 → PARITY.
- PARITY: latch rxParity←serialData → STOP.
- STOP:
  - serialData=1: outputData←shift, parityError←(rxParity ≠ p), pulse outputValid → IDLE.
  - serialData=0: pulse frameError; outputData and parityError unchanged → IDLE.
- The stop bit is never reused as a start bit. After STOP, the next strobe is examined in IDLE.
- The bitCount width is $clog2(DATA_WIDTH), minimum 1. The counter never wraps past DATA_WIDTH-1.
- No backpressure: the consumer must take outputData within the frame time. The value remains stable until the next good frame.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clock edge):
  - State → IDLE.
  - outputData → 0, outputValid → 0, parityError → 0, frameError → 0, busy → 0.
  - Internal shift register, p and bitCount → 0.
- Reset mid-frame aborts the frame with no pulses. The first strobe after release is treated as an IDLE sample.
- All outputs are registered. outputValid or frameError asserts on the clock edge that samples the stop bit, and deasserts on the next edge.
- busy rises on the edge that samples the start bit. It falls on the edge that samples the stop bit.
- Frame length is DATA_WIDTH+3 strobes; minimum DATA_WIDTH+3 cycles with continuous serialValid.
- Back-to-back frames: a start bit on the strobe immediately after the stop bit is accepted (zero idle bits required).
- serialValid gaps of any length mid-frame are tolerated; there is no timeout.

## Test plan
- DATA_WIDTH=8, continuous strobes, frame 0,1,0,1,0,0,1,0,1 (0xA5 LSB first), parity 1, stop 1 → outputValid pulse 11 cycles after the start strobe; outputData=0xA5; parityError=0; busy low afterwards.
- Same frame with parity 0 → outputValid pulse; outputData=0xA5; parityError=1.
- 0x00 with parity 1, then 0x01 with parity 0, back-to-back with no idle bit → two outputValid pulses 11 cycles apart; data 0x00 then 0x01; parityError=0 for both.
- Good frame 0x3C, then frame 0xFF with stop bit 0 → frameError one-cycle pulse; no outputValid; outputData stays 0x3C.
- Idle strobes with serialData=1 for 20 cycles → stays IDLE, busy=0. Frame 0x81 with random serialValid gaps of 0–5 cycles → correct 0x81, parityError=0.
- Assert Reset_n=0 after 4 data bits of a frame → all outputs 0 immediately. Release, then send 0x5A → correct reception. Also with DATA_WIDTH=1: data 1, parity 1 → parityError=0.

Source files
------------

// File: rtl/_xnor_rx_if.sv
// Bit-level input and word-level output bundle of the XNOR-parity frame receiver.
interface _xnor_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serialData;
  logic                  serialValid;
  logic [DATA_WIDTH-1:0] outputData;
  logic                  outputValid;
  logic                  parityError;
  logic                  frameError;
  logic                  busy;

  modport master (
    output serialData, serialValid,
    input  outputData, outputValid, parityError, frameError, busy
  );

  modport slave (
    input  serialData, serialValid,
    output outputData, outputValid, parityError, frameError, busy
  );
endinterface

// File: rtl/_xnor_rx.sv
// Framed serial receiver: start, DATA_WIDTH data bits LSB first, XNOR-chain parity, stop.
// state  | meaning
// IDLE   | waiting for a 0 start bit on a strobe
// DATA   | shifting data bits in, updating running parity
// PARITY | capturing the received parity bit
// STOP   | checking stop bit, publishing word or flagging frame error
module _xnor_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [1:0] DigitSupply,
  _xnor_rx_if.slave  rx
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         bit_count;
  logic [DATA_WIDTH-1:0] shift;
  logic                  p;
  logic                  rx_parity;

  // Only the logic-1 rail seeds the chain; the logic-0 rail is carried for symmetry with _xnor.
  logic rail_unused;
  assign rail_unused = DigitSupply[0];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      bit_count      <= '0;
      shift          <= '0;
      p              <= 1'b0;
      rx_parity      <= 1'b0;
      rx.outputData  <= '0;
      rx.outputValid <= 1'b0;
      rx.parityError <= 1'b0;
      rx.frameError  <= 1'b0;
      rx.busy        <= 1'b0;
    end else begin
      rx.outputValid <= 1'b0;
      rx.frameError  <= 1'b0;
      if (rx.serialValid) begin
        case (state)
          IDLE: begin
            if (!rx.serialData) begin
              state     <= DATA;
              bit_count <= '0;
              p         <= DigitSupply[1];
              rx.busy   <= 1'b1;
            end
          end
          DATA: begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (bit_count == CW'(i)) shift[i] <= rx.serialData;
            end
            p <= ~(p ^ rx.serialData);
            // Counter parks on the last index instead of wrapping.
            if (bit_count == LAST) state <= PARITY;
            else                   bit_count <= bit_count + 1'b1;
          end
          PARITY: begin
            rx_parity <= rx.serialData;
            state     <= STOP;
          end
          STOP: begin
            state   <= IDLE;
            rx.busy <= 1'b0;
            if (rx.serialData) begin
              rx.outputData  <= shift;
              rx.parityError <= rx_parity ^ p;
              rx.outputValid <= 1'b1;
            end else begin
              rx.frameError  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
